// File: rtl/johnson_counter_param_if.sv
// johnson_counter_param_if
//   Bundles the control inputs and status outputs of johnson_counter_param.
//   The clock and reset are not part of the bundle.
//   master : drives en/dir/load/load_val and observes q/phase/wrap/illegal
//   slave  : the counter side
// Ports (signals)
//   en       advance one step
//   dir      1 = forward, 0 = reverse
//   load     load load_val into q
//   load_val raw pattern to load (WIDTH bits)
//   q        counter state (WIDTH bits)
//   phase    step index 0..2*WIDTH-1 (PW bits)
//   wrap     one-cycle pulse after a step across the sequence boundary
//   illegal  q is not a legal Johnson pattern
interface johnson_counter_param_if #(
   parameter int WIDTH = 4
);
   localparam int PW = $clog2(2*WIDTH);

   logic             en;
   logic             dir;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic [PW-1:0]    phase;
   logic             wrap;
   logic             illegal;

   modport master (
      output en, dir, load, load_val,
      input  q, phase, wrap, illegal
   );

   modport slave (
      input  en, dir, load, load_val,
      output q, phase, wrap, illegal
   );
endinterface

// File: rtl/johnson_counter_param.sv
// johnson_counter_param
//   WIDTH-bit Johnson (twisted-ring) counter with enable, direction, parallel
//   load, decoded phase index and a registered wrap pulse.
//   Optional feature macro: JOHNSON_SELF_CORRECT_EN -- when defined, an
//   illegal pattern in q is flagged and forced back to zero on the next edge
//   that does not load. When undefined, illegal is tied low.
// Ports
//   clk      rising-edge clock
//   reset_n  synchronous reset, active low (q=0, wrap=0)
//   bus      johnson_counter_param_if slave modport (en, dir, load,
//            load_val in; q, phase, wrap, illegal out)
module johnson_counter_param #(
   parameter int WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   johnson_counter_param_if.slave   bus
);
   localparam int PW  = $clog2(2*WIDTH);
   localparam int PCW = PW + 1;

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;
   logic             illegal;
   logic [PW:0]      pop;
   logic [PW:0]      phase_full;

   // Phase decode: leading ones count up, trailing ones count down from 2*WIDTH.
   always_comb begin
      pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + {{PW{1'b0}}, q_q[i]};
      end
      if (q_q[WIDTH-1]) begin
         phase_full = pop;
      end else if (pop == '0) begin
         phase_full = '0;
      end else begin
         phase_full = PCW'(2*WIDTH) - pop;
      end
   end

`ifdef JOHNSON_SELF_CORRECT_EN
   // A legal pattern has at most one 0/1 boundary between adjacent bits.
   logic [PW:0] edges;
   always_comb begin
      edges = '0;
      for (int i = 0; i < WIDTH-1; i++) begin
         edges = edges + {{PW{1'b0}}, q_q[i] ^ q_q[i+1]};
      end
      illegal = (edges > PCW'(1));
   end
`else
   assign illegal = 1'b0;
`endif

   // Wrap is keyed on the actual boundary patterns (0..01 forward, 0 reverse)
   // so an illegal circulating pattern can never raise it.
   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      if (bus.load) begin
         q_d = bus.load_val;
      end else if (illegal) begin
         q_d = '0;
      end else if (bus.en) begin
         if (bus.dir) begin
            q_d    = {~q_q[0], q_q[WIDTH-1:1]};
            wrap_d = (q_q == WIDTH'(1));
         end else begin
            q_d    = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
            wrap_d = (q_q == '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.q       = q_q;
   assign bus.phase   = phase_full[PW-1:0];
   assign bus.wrap    = wrap_q;
   assign bus.illegal = illegal;
endmodule

// File: tb/tb_johnson_counter_param.sv
// tb_johnson_counter_param
//   Scoreboard bench for johnson_counter_param at WIDTH=4 (main), plus
//   WIDTH=2 and WIDTH=7 instances for full forward/reverse rings.
//   Honours JOHNSON_SELF_CORRECT_EN the same way as the design.
module tb_johnson_counter_param;
`ifdef JOHNSON_SELF_CORRECT_EN
   localparam bit SC = 1'b1;
`else
   localparam bit SC = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   johnson_counter_param_if #(.WIDTH(4)) bus4 ();
   johnson_counter_param_if #(.WIDTH(2)) bus2 ();
   johnson_counter_param_if #(.WIDTH(7)) bus7 ();

   johnson_counter_param #(.WIDTH(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));
   johnson_counter_param #(.WIDTH(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));
   johnson_counter_param #(.WIDTH(7)) dut7 (.clk(clk), .reset_n(reset_n), .bus(bus7));

   typedef struct {
      logic [7:0] q;
      int         ph;
      logic       wrap;
      logic       ill;
   } exp_t;

   exp_t sb4[$];
   exp_t sb2[$];
   exp_t sb7[$];

   int n_chk  = 0;
   int n_fail = 0;

   logic [3:0] m_q  = '0;
   int         m_ph = 0;
   int         p2   = 0;
   int         p7   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Reference pattern for step k of a w-bit ring, built from the documented
   // sequence shape rather than by shifting.
   function automatic logic [7:0] jpat(input int w, input int k);
      logic [7:0] v;
      v = '0;
      for (int i = 0; i < w; i++) begin
         if (k <= w) v[i] = (i >= w - k);
         else        v[i] = (i < 2*w - k);
      end
      return v;
   endfunction

   function automatic int find_ph(input int w, input logic [7:0] v);
      for (int k = 0; k < 2*w; k++) begin
         if (jpat(w, k) == v) return k;
      end
      return -1;
   endfunction

   // One clock for the WIDTH=4 instance; small instances held (reset still applies).
   task automatic cyc(input logic rst, input logic en, input logic dir,
                      input logic ld, input logic [3:0] lv);
      exp_t e;
      logic [7:0] t;
      reset_n       = rst;
      bus4.en       = en;
      bus4.dir      = dir;
      bus4.load     = ld;
      bus4.load_val = lv;
      bus2.en       = 1'b0;
      bus7.en       = 1'b0;
      e.wrap = 1'b0;
      if (!rst) begin
         m_q = '0; m_ph = 0; p2 = 0; p7 = 0;
      end else if (ld) begin
         m_q  = lv;
         m_ph = find_ph(4, {4'b0, lv});
      end else if (m_ph < 0 && SC) begin
         m_q = '0; m_ph = 0;
      end else if (en) begin
         if (m_ph < 0) begin
            m_q = dir ? {~m_q[0], m_q[3:1]} : {m_q[2:0], ~m_q[3]};
         end else begin
            e.wrap = dir ? (m_ph == 7) : (m_ph == 0);
            m_ph   = dir ? (m_ph + 1) % 8 : (m_ph + 7) % 8;
            t      = jpat(4, m_ph);
            m_q    = t[3:0];
         end
      end
      e.q   = {4'b0, m_q};
      e.ph  = m_ph;
      e.ill = SC && (m_ph < 0);
      sb4.push_back(e);
      @(posedge clk);
      #1;
      e = sb4.pop_front();
      chk("q4", {28'b0, bus4.q}, {24'b0, e.q});
      if (e.ph >= 0) chk("phase4", {29'b0, bus4.phase}, e.ph);
      chk("wrap4", {31'b0, bus4.wrap}, {31'b0, e.wrap});
      chk("illegal4", {31'b0, bus4.illegal}, {31'b0, e.ill});
   endtask

   // One clock stepping both small rings; main instance holds.
   task automatic cyc_small(input logic dir);
      exp_t e2, e7;
      reset_n   = 1'b1;
      bus4.en   = 1'b0;
      bus4.load = 1'b0;
      bus2.en   = 1'b1; bus2.dir = dir;
      bus7.en   = 1'b1; bus7.dir = dir;
      e2.wrap = dir ? (p2 == 3)  : (p2 == 0);
      e7.wrap = dir ? (p7 == 13) : (p7 == 0);
      p2 = dir ? (p2 + 1) % 4  : (p2 + 3) % 4;
      p7 = dir ? (p7 + 1) % 14 : (p7 + 13) % 14;
      e2.q = jpat(2, p2); e2.ph = p2; e2.ill = 1'b0;
      e7.q = jpat(7, p7); e7.ph = p7; e7.ill = 1'b0;
      sb2.push_back(e2);
      sb7.push_back(e7);
      @(posedge clk);
      #1;
      e2 = sb2.pop_front();
      e7 = sb7.pop_front();
      chk("q2", {30'b0, bus2.q}, {24'b0, e2.q});
      chk("phase2", {30'b0, bus2.phase}, e2.ph);
      chk("wrap2", {31'b0, bus2.wrap}, {31'b0, e2.wrap});
      chk("q7", {25'b0, bus7.q}, {24'b0, e7.q});
      chk("phase7", {28'b0, bus7.phase}, e7.ph);
      chk("wrap7", {31'b0, bus7.wrap}, {31'b0, e7.wrap});
   endtask

   initial begin
      logic [7:0] t;
      bus4.en = 1'b0; bus4.dir = 1'b1; bus4.load = 1'b0; bus4.load_val = '0;
      bus2.en = 1'b0; bus2.dir = 1'b1; bus2.load = 1'b0; bus2.load_val = '0;
      bus7.en = 1'b0; bus7.dir = 1'b1; bus7.load = 1'b0; bus7.load_val = '0;

      // reset wins over load and enable
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b1010);
      chk("reset_wrap2", {31'b0, bus2.wrap}, 32'd0);
      chk("reset_q7", {25'b0, bus7.q}, 32'd0);

      // full forward ring, wrap only after the 8th step
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'b0);

      // reverse one step then hold three
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0);

      // forward to 1100, then load beats enable
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'b0);
      chk("at_1100", {28'b0, bus4.q}, 32'hC);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'b0111);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'b0);

      // random enable/direction with occasional legal loads
      for (int i = 0; i < 40; i++) begin
         t = jpat(4, $urandom_range(0, 7));
         cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 7) == 0), t[3:0]);
      end

      // mid-sequence reset and resume
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'b1110);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'b0);

      // illegal pattern load
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'b0101);
      cyc(1'b1, SC ? 1'b0 : 1'b1, 1'b1, 1'b0, 4'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);

      // small rings: 14 forward then 14 reverse steps
      for (int i = 0; i < 14; i++) cyc_small(1'b1);
      chk("w7_fwd_home", {25'b0, bus7.q}, 32'd0);
      for (int i = 0; i < 14; i++) cyc_small(1'b0);
      chk("w2_rev_home", {30'b0, bus2.q}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
